// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: data TCM responder that arbitrates a core port and a DMA port onto one single-port SRAM.
// Optional per-byte even parity (storage, check and dtcm_parity_err) when KRV_DTCM_PARITY_EN is defined.
module dtcm_ctrl #(
  parameter int DTCM_SIZE_BYTES = 65536,
  parameter int MAX_WAIT        = 8,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  data_dtcm_access,
  output logic                  data_dtcm_ready,
  input  logic                  data_dtcm_rd0_wr1,
  input  logic [3:0]            data_dtcm_byte_strobe,
  input  logic [31:0]           data_dtcm_write_data,
  input  logic [ADDR_WIDTH-1:0] data_dtcm_addr,
  output logic [31:0]           data_dtcm_read_data,
  output logic                  data_dtcm_read_data_valid,
  input  logic                  dma_access,
  output logic                  dma_ready,
  input  logic                  dma_rd0_wr1,
  input  logic [3:0]            dma_byte_strobe,
  input  logic [31:0]           dma_write_data,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [31:0]           dma_read_data,
`ifdef KRV_DTCM_PARITY_EN
  output logic                  dtcm_parity_err,
`endif
  output logic                  dma_read_data_valid
);

  localparam int IDX_HI  = $clog2(DTCM_SIZE_BYTES);
  localparam int WORD_AW = IDX_HI - 2;
  localparam int DEPTH   = DTCM_SIZE_BYTES / 4;
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  // Handshakes: a core read is a one-cycle pulse that is always taken; a core write is
  // taken when access && data_dtcm_ready, else the core holds it; a DMA command is held
  // on dma_access until the cycle dma_ready=1. Read data returns one cycle after the take.
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               dma_urgent;
  logic               core_rd_grant, core_wr_grant, dma_grant, dma_rd_grant;
  logic               sram_we;
  logic [WORD_AW-1:0] core_idx, dma_idx, sram_idx;
  logic [3:0]         sram_strb;
  logic [31:0]        sram_wdata, sram_rword;
  logic [31:0]        mem [DEPTH];

  logic               core_rd_valid_q, core_rd_valid_d;
  logic [31:0]        core_rd_data_q, core_rd_data_d;
  logic               dma_rd_valid_q, dma_rd_valid_d;
  logic [31:0]        dma_rd_data_q, dma_rd_data_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_dtcm_addr[ADDR_WIDTH-1:IDX_HI], data_dtcm_addr[1:0],
                              dma_addr[ADDR_WIDTH-1:IDX_HI], dma_addr[1:0]};

  assign core_idx = data_dtcm_addr[IDX_HI-1:2];
  assign dma_idx  = dma_addr[IDX_HI-1:2];

  always_comb begin
    dma_urgent    = dma_access && (wait_cnt_q == WAIT_MAX);
    // A refused core read would deadlock the core, so it beats even an urgent DMA.
    core_rd_grant = data_dtcm_access && !data_dtcm_rd0_wr1;
    core_wr_grant = data_dtcm_access && data_dtcm_rd0_wr1 && !dma_urgent;
    dma_grant     = dma_access && (!data_dtcm_access || (dma_urgent && data_dtcm_rd0_wr1));
    dma_rd_grant  = dma_grant && !dma_rd0_wr1;
    sram_we       = core_wr_grant || (dma_grant && dma_rd0_wr1);
    sram_idx      = dma_grant ? dma_idx : core_idx;
    sram_strb     = dma_grant ? dma_byte_strobe : data_dtcm_byte_strobe;
    sram_wdata    = dma_grant ? dma_write_data : data_dtcm_write_data;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dma_access || dma_grant) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    sram_rword      = mem[sram_idx];
    core_rd_valid_d = core_rd_grant;
    core_rd_data_d  = core_rd_grant ? sram_rword : core_rd_data_q;
    dma_rd_valid_d  = dma_rd_grant;
    dma_rd_data_d   = dma_rd_grant ? sram_rword : dma_rd_data_q;
  end

  // Storage is not reset; only strobed byte lanes are written.
  always_ff @(posedge cpu_clk) begin
    if (sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_strb[b]) mem[sram_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wait_cnt_q      <= 8'd0;
      core_rd_valid_q <= 1'b0;
      core_rd_data_q  <= 32'd0;
      dma_rd_valid_q  <= 1'b0;
      dma_rd_data_q   <= 32'd0;
    end else begin
      wait_cnt_q      <= wait_cnt_d;
      core_rd_valid_q <= core_rd_valid_d;
      core_rd_data_q  <= core_rd_data_d;
      dma_rd_valid_q  <= dma_rd_valid_d;
      dma_rd_data_q   <= dma_rd_data_d;
    end
  end

  assign data_dtcm_ready           = !dma_urgent;
  assign dma_ready                 = dma_grant;
  assign data_dtcm_read_data       = core_rd_data_q;
  assign data_dtcm_read_data_valid = core_rd_valid_q;
  assign dma_read_data             = dma_rd_data_q;
  assign dma_read_data_valid       = dma_rd_valid_q;

`ifdef KRV_DTCM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_rd;
  logic       par_err_q, par_err_d;

  always_ff @(posedge cpu_clk) begin
    if (sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_strb[b]) par_mem[sram_idx][b] <= ^sram_wdata[8*b +: 8];
      end
    end
  end

  // All four lanes are checked on a read, whatever strobe came with it.
  always_comb begin
    par_rd    = par_mem[sram_idx];
    par_err_d = 1'b0;
    if (core_rd_grant || dma_rd_grant) begin
      for (int b = 0; b < 4; b++) begin
        if ((^sram_rword[8*b +: 8]) != par_rd[b]) par_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) par_err_q <= 1'b0;
    else           par_err_q <= par_err_d;
  end

  assign dtcm_parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Self-checking bench for dtcm_ctrl: directed scenarios plus a randomized mixed-port run
// checked against a word-array memory model and per-port expected-data queues.
`timescale 1ns/1ps
module tb_dtcm_ctrl;

  localparam int DTCM_SIZE_BYTES = 65536;
  localparam int MAX_WAIT        = 8;
  localparam int AW              = 32;
  localparam int N_RAND          = 600;

  logic          cpu_clk, cpu_rstn;
  logic          c_access, c_ready, c_wr, c_rvalid;
  logic [3:0]    c_strb;
  logic [31:0]   c_wdata, c_rdata;
  logic [AW-1:0] c_addr;
  logic          d_access, d_ready, d_wr, d_rvalid;
  logic [3:0]    d_strb;
  logic [31:0]   d_wdata, d_rdata;
  logic [AW-1:0] d_addr;
`ifdef KRV_DTCM_PARITY_EN
  logic          parity_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [0:DTCM_SIZE_BYTES/4-1];
  logic [31:0] core_exp_q[$];
  logic [31:0] dma_exp_q[$];

  dtcm_ctrl #(.DTCM_SIZE_BYTES(DTCM_SIZE_BYTES), .MAX_WAIT(MAX_WAIT), .ADDR_WIDTH(AW)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .data_dtcm_access(c_access), .data_dtcm_ready(c_ready), .data_dtcm_rd0_wr1(c_wr),
    .data_dtcm_byte_strobe(c_strb), .data_dtcm_write_data(c_wdata), .data_dtcm_addr(c_addr),
    .data_dtcm_read_data(c_rdata), .data_dtcm_read_data_valid(c_rvalid),
    .dma_access(d_access), .dma_ready(d_ready), .dma_rd0_wr1(d_wr),
    .dma_byte_strobe(d_strb), .dma_write_data(d_wdata), .dma_addr(d_addr),
    .dma_read_data(d_rdata),
`ifdef KRV_DTCM_PARITY_EN
    .dtcm_parity_err(parity_err),
`endif
    .dma_read_data_valid(d_rvalid)
  );

  // Clock and reset
  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Model helpers
  function automatic int widx(input logic [31:0] a);
    return int'((a & 32'(DTCM_SIZE_BYTES - 1)) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] idx;
    idx = 32'($urandom_range(0, 15));
    return ($urandom & 32'hFFFF_0003) | (idx << 2);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    model_mem[widx(a)] = merge(model_mem[widx(a)], d, s);
  endtask

  // Drivers
  task automatic idle();
    c_access = 1'b0; c_wr = 1'b0; c_strb = 4'h0; c_wdata = 32'h0; c_addr = '0;
    d_access = 1'b0; d_wr = 1'b0; d_strb = 4'h0; d_wdata = 32'h0; d_addr = '0;
  endtask

  task automatic drive_core(input logic wr, input logic [3:0] s, input logic [31:0] d, input logic [31:0] a);
    c_access = 1'b1; c_wr = wr; c_strb = s; c_wdata = d; c_addr = a;
  endtask

  task automatic drive_dma(input logic wr, input logic [3:0] s, input logic [31:0] d, input logic [31:0] a);
    d_access = 1'b1; d_wr = wr; d_strb = s; d_wdata = d; d_addr = a;
  endtask

  // Scenarios
  task automatic test_reset();
    cpu_rstn = 1'b0;
    idle();
    repeat (2) @(negedge cpu_clk);
    tests_run++; if (c_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_core_valid: got %b expected 0", c_rvalid); end
    tests_run++; if (c_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_core_data: got %h expected 0", c_rdata); end
    tests_run++; if (d_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_dma_valid: got %b expected 0", d_rvalid); end
    tests_run++; if (d_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_dma_data: got %h expected 0", d_rdata); end
    tests_run++; if (c_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_core_ready: got %b expected 1", c_ready); end
    tests_run++; if (d_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_dma_ready: got %b expected 0", d_ready); end
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
  endtask

  task automatic test_sw_lw();
    @(negedge cpu_clk);
    drive_core(1'b1, 4'hF, 32'hDEADBEEF, 32'h10);
    #1;
    tests_run++; if (c_ready !== 1'b1) begin tests_failed++; $display("FAIL sw_ready: got %b expected 1", c_ready); end
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge cpu_clk);
    drive_core(1'b0, 4'hF, 32'h0, 32'h10);
    @(negedge cpu_clk);
    c_access = 1'b0;
    tests_run++; if (c_rvalid !== 1'b1) begin tests_failed++; $display("FAIL lw_valid: got %b expected 1", c_rvalid); end
    tests_run++; if (c_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data: got %h expected deadbeef", c_rdata); end
    @(negedge cpu_clk);
    tests_run++; if (c_rvalid !== 1'b0) begin tests_failed++; $display("FAIL lw_valid_pulse: got %b expected 0", c_rvalid); end
    tests_run++; if (c_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data_hold: got %h expected deadbeef", c_rdata); end
  endtask

  task automatic test_sb();
    @(negedge cpu_clk);
    drive_core(1'b1, 4'b0100, 32'h00AA0000, 32'h10);
    model_write(32'h10, 32'h00AA0000, 4'b0100);
    @(negedge cpu_clk);
    drive_core(1'b0, 4'h0, 32'h0, 32'h10);
    @(negedge cpu_clk);
    c_access = 1'b0;
    tests_run++; if (c_rdata !== 32'hDEAABEEF || c_rvalid !== 1'b1) begin tests_failed++; $display("FAIL sb_data: got %h/%b expected deaabeef/1", c_rdata, c_rvalid); end
    // zero-strobe write must leave the word untouched
    drive_core(1'b1, 4'b0000, 32'hFFFFFFFF, 32'h10);
    @(negedge cpu_clk);
    drive_core(1'b0, 4'h0, 32'h0, 32'h10);
    @(negedge cpu_clk);
    c_access = 1'b0;
    tests_run++; if (c_rdata !== 32'hDEAABEEF) begin tests_failed++; $display("FAIL strobe0_noop: got %h expected deaabeef", c_rdata); end
  endtask

  task automatic test_dma_starve();
    logic [31:0] exp_d, held;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < MAX_WAIT; i++) begin
        drive_dma(1'b0, 4'hF, 32'h0, (r == 0) ? 32'h10 : 32'h20);
        held = $urandom;
        drive_core(1'b1, 4'hF, held, 32'h20);
        #1;
        tests_run++; if (d_ready !== 1'b0) begin tests_failed++; $display("FAIL starve_dma_ready r%0d c%0d: got %b expected 0", r, i, d_ready); end
        tests_run++; if (c_ready !== 1'b1) begin tests_failed++; $display("FAIL starve_core_ready r%0d c%0d: got %b expected 1", r, i, c_ready); end
        model_write(32'h20, held, 4'hF);
        @(negedge cpu_clk);
      end
      held = $urandom;
      drive_core(1'b1, 4'hF, held, 32'h20);
      #1;
      tests_run++; if (c_ready !== 1'b0) begin tests_failed++; $display("FAIL urgent_core_ready r%0d: got %b expected 0", r, c_ready); end
      tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL urgent_dma_ready r%0d: got %b expected 1", r, d_ready); end
      exp_d = model_mem[widx(d_addr)];
      @(negedge cpu_clk);
      d_access = 1'b0;
      tests_run++; if (d_rvalid !== 1'b1 || d_rdata !== exp_d) begin tests_failed++; $display("FAIL starve_dma_data r%0d: got %h/%b expected %h/1", r, d_rdata, d_rvalid, exp_d); end
      #1;
      tests_run++; if (c_ready !== 1'b1) begin tests_failed++; $display("FAIL retry_core_ready r%0d: got %b expected 1", r, c_ready); end
      model_write(32'h20, held, 4'hF);
      @(negedge cpu_clk);
    end
    idle();
  endtask

  task automatic test_urgent_vs_read();
    logic [31:0] exp_w;
    @(negedge cpu_clk);
    for (int i = 0; i < MAX_WAIT; i++) begin
      drive_dma(1'b0, 4'hF, 32'h0, 32'h10);
      drive_core(1'b1, 4'hF, 32'h1234_0000 + 32'(i), 32'h20);
      model_write(32'h20, 32'h1234_0000 + 32'(i), 4'hF);
      @(negedge cpu_clk);
    end
    drive_core(1'b0, 4'h0, 32'h0, 32'h20);
    #1;
    tests_run++; if (c_ready !== 1'b0 || d_ready !== 1'b0) begin tests_failed++; $display("FAIL rd_vs_urgent_grant: got c_ready=%b d_ready=%b expected 0/0", c_ready, d_ready); end
    exp_w = model_mem[widx(32'h20)];
    @(negedge cpu_clk);
    c_access = 1'b0;
    tests_run++; if (c_rvalid !== 1'b1 || c_rdata !== exp_w) begin tests_failed++; $display("FAIL rd_vs_urgent_core: got %h/%b expected %h/1", c_rdata, c_rvalid, exp_w); end
    #1;
    tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL rd_vs_urgent_dma_next: got %b expected 1", d_ready); end
    exp_w = model_mem[widx(32'h10)];
    @(negedge cpu_clk);
    d_access = 1'b0;
    tests_run++; if (d_rvalid !== 1'b1 || d_rdata !== exp_w) begin tests_failed++; $display("FAIL rd_vs_urgent_dma_data: got %h/%b expected %h/1", d_rdata, d_rvalid, exp_w); end
    idle();
  endtask

  task automatic test_wrap();
    @(negedge cpu_clk);
    drive_core(1'b1, 4'hF, 32'hCAFE0123, 32'h10);
    model_write(32'h10, 32'hCAFE0123, 4'hF);
    @(negedge cpu_clk);
    c_access = 1'b0;
    drive_dma(1'b0, 4'hF, 32'h0, 32'h0001_0010);
    @(negedge cpu_clk);
    d_access = 1'b0;
    tests_run++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0123) begin tests_failed++; $display("FAIL wrap_dma_read: got %h/%b expected cafe0123/1", d_rdata, d_rvalid); end
    drive_dma(1'b1, 4'hF, 32'h5A5A1234, 32'hFFFF_0017);
    model_write(32'hFFFF_0017, 32'h5A5A1234, 4'hF);
    @(negedge cpu_clk);
    d_access = 1'b0;
    drive_core(1'b0, 4'h0, 32'h0, 32'h14);
    @(negedge cpu_clk);
    c_access = 1'b0;
    tests_run++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h5A5A1234) begin tests_failed++; $display("FAIL wrap_core_read: got %h/%b expected 5a5a1234/1", c_rdata, c_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5];
    logic [31:0] exp_w;
    addrs[0] = 32'h40; addrs[1] = 32'h10; addrs[2] = 32'h14; addrs[3] = 32'h20; addrs[4] = 32'h40;
    @(negedge cpu_clk);
    drive_core(1'b1, 4'hF, 32'h0BADF00D, 32'h40);
    model_write(32'h40, 32'h0BADF00D, 4'hF);
    for (int k = 0; k <= 5; k++) begin
      @(negedge cpu_clk);
      if (k > 0) begin
        exp_w = core_exp_q.pop_front();
        tests_run++; if (c_rvalid !== 1'b1 || c_rdata !== exp_w) begin tests_failed++; $display("FAIL b2b_read%0d: got %h/%b expected %h/1", k, c_rdata, c_rvalid, exp_w); end
      end
      if (k < 5) begin
        drive_core(1'b0, 4'h0, 32'h0, addrs[k]);
        core_exp_q.push_back(model_mem[widx(addrs[k])]);
      end else begin
        c_access = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_w;
    @(negedge cpu_clk);
    for (int i = 0; i < 5; i++) begin
      drive_dma(1'b0, 4'hF, 32'h0, 32'h14);
      drive_core(1'b1, 4'hF, 32'h7700_0000 + 32'(i), 32'h20);
      model_write(32'h20, 32'h7700_0000 + 32'(i), 4'hF);
      @(negedge cpu_clk);
    end
    drive_core(1'b0, 4'h0, 32'h0, 32'h10);
    @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b0;
    idle();
    @(negedge cpu_clk);
    tests_run++; if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin tests_failed++; $display("FAIL midreset_core: got %h/%b expected 0/0", c_rdata, c_rvalid); end
    tests_run++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || d_ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_dma: got %h/%b/%b expected 0/0/0", d_rdata, d_rvalid, d_ready); end
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);
    // the refusal count must restart from zero after reset
    for (int i = 0; i < MAX_WAIT; i++) begin
      drive_dma(1'b0, 4'hF, 32'h0, 32'h14);
      drive_core(1'b1, 4'hF, 32'h6600_0000 + 32'(i), 32'h20);
      #1;
      tests_run++; if (d_ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_wait c%0d: got %b expected 0", i, d_ready); end
      model_write(32'h20, 32'h6600_0000 + 32'(i), 4'hF);
      @(negedge cpu_clk);
    end
    drive_core(1'b1, 4'hF, 32'h0, 32'h20);
    #1;
    tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_urgent: got %b expected 1", d_ready); end
    exp_w = model_mem[widx(32'h14)];
    @(negedge cpu_clk);
    idle();
    tests_run++; if (d_rvalid !== 1'b1 || d_rdata !== exp_w) begin tests_failed++; $display("FAIL midreset_dma_data: got %h/%b expected %h/1", d_rdata, d_rvalid, exp_w); end
  endtask

  task automatic test_random();
    bit cp, cw, dp, dw, prev_c, prev_d, urg, g_crd, g_cwr, g_d;
    logic [3:0]  cs, ds;
    logic [31:0] cd, dd, ca, da, exp_w;
    int streak;
    // Prefill the 16-word pool through the DMA port
    for (int i = 0; i < 16; i++) begin
      @(negedge cpu_clk);
      da = ($urandom & 32'hFFFF_0003) | (32'(i) << 2);
      dd = $urandom;
      drive_dma(1'b1, 4'hF, dd, da);
      #1;
      tests_run++; if (d_ready !== 1'b1) begin tests_failed++; $display("FAIL prefill_ready w%0d: got %b expected 1", i, d_ready); end
      model_write(da, dd, 4'hF);
    end
    @(negedge cpu_clk);
    idle();
    cp = 0; dp = 0; cw = 0; dw = 0; prev_c = 0; prev_d = 0; streak = 0;
    cs = 0; ds = 0; cd = 0; dd = 0; ca = 0; da = 0;
    for (int cyc = 0; cyc < N_RAND + 30; cyc++) begin
      @(negedge cpu_clk);
      tests_run++; if (c_rvalid !== prev_c) begin tests_failed++; $display("FAIL rand_core_valid cyc%0d: got %b expected %b", cyc, c_rvalid, prev_c); end
      if (prev_c) begin
        exp_w = core_exp_q.pop_front();
        tests_run++; if (c_rdata !== exp_w) begin tests_failed++; $display("FAIL rand_core_data cyc%0d: got %h expected %h", cyc, c_rdata, exp_w); end
      end
      tests_run++; if (d_rvalid !== prev_d) begin tests_failed++; $display("FAIL rand_dma_valid cyc%0d: got %b expected %b", cyc, d_rvalid, prev_d); end
      if (prev_d) begin
        exp_w = dma_exp_q.pop_front();
        tests_run++; if (d_rdata !== exp_w) begin tests_failed++; $display("FAIL rand_dma_data cyc%0d: got %h expected %h", cyc, d_rdata, exp_w); end
      end
      if (!cp && cyc < N_RAND && $urandom_range(0, 1) == 1) begin
        cp = 1; cw = 1'($urandom_range(0, 1)); cs = 4'($urandom); cd = $urandom; ca = rand_addr();
      end
      if (!dp && cyc < N_RAND && $urandom_range(0, 2) == 0) begin
        dp = 1; dw = 1'($urandom_range(0, 1)); ds = 4'($urandom); dd = $urandom; da = rand_addr();
      end
      c_access = cp; c_wr = cw; c_strb = cs; c_wdata = cd; c_addr = ca;
      d_access = dp; d_wr = dw; d_strb = ds; d_wdata = dd; d_addr = da;
      #1;
      urg   = dp && (streak == MAX_WAIT);
      g_crd = cp && !cw;
      g_cwr = cp && cw && !urg;
      g_d   = dp && (!cp || (urg && cw));
      tests_run++; if (c_ready !== !urg) begin tests_failed++; $display("FAIL rand_core_ready cyc%0d: got %b expected %b", cyc, c_ready, !urg); end
      tests_run++; if (d_ready !== g_d) begin tests_failed++; $display("FAIL rand_dma_ready cyc%0d: got %b expected %b", cyc, d_ready, g_d); end
      if (g_cwr) model_write(ca, cd, cs);
      if (g_d && dw) model_write(da, dd, ds);
      if (g_crd) core_exp_q.push_back(model_mem[widx(ca)]);
      if (g_d && !dw) dma_exp_q.push_back(model_mem[widx(da)]);
      prev_c = g_crd;
      prev_d = g_d && !dw;
      if (dp && !g_d) streak = (streak < MAX_WAIT) ? streak + 1 : streak;
      else            streak = 0;
      if (g_crd || g_cwr) cp = 0;
      if (g_d) dp = 0;
    end
    idle();
    tests_run++; if (core_exp_q.size() != 0 || dma_exp_q.size() != 0) begin tests_failed++; $display("FAIL rand_drain_queues: got %0d/%0d expected 0/0", core_exp_q.size(), dma_exp_q.size()); end
    tests_run++; if (cp || dp) begin tests_failed++; $display("FAIL rand_drain_pending: got core=%b dma=%b expected 0/0", cp, dp); end
  endtask

  initial begin
    idle();
    cpu_rstn = 1'b0;
    test_reset();
    test_sw_lw();
    test_sb();
    test_dma_starve();
    test_urgent_vs_read();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
